// File: rtl/decode_mul_pipe.sv
//------------------------------------------------------------------------------
// decode_mul_pipe
//   Pipelined fixed-point multiplier for the decode datapath. The operands are
//   signed or unsigned as set by parameter. The exact product is arithmetically
//   right-shifted by SHIFT, with optional round-half-up. The result is then
//   clamped (SAT=1) or wrapped (SAT=0). ovf reports that the shifted value did
//   not fit the output range.
//
//   Pipeline split: NUM_STAGE-1 registers carry the exact product. The last
//   stage does the round/shift/saturate in combinational logic and then
//   registers dout/ovf/dout_vld. When NUM_STAGE=1, the multiply feeds the
//   output register directly.
//
// Ports
//   clk       in   clock
//   reset     in   asynchronous active-low reset; clears all stages
//   ce        in   pipeline advance enable; 0 holds every stage and the outputs
//   din_vld   in   operands valid this cycle
//   din0      in   operand A (din0_WIDTH)
//   din1      in   operand B (din1_WIDTH)
//   dout_vld  out  result valid
//   dout      out  result (dout_WIDTH)
//   ovf       out  result was clamped or wrapped; meaningful when dout_vld=1
//
// Handshake: there is no backpressure. A beat is accepted on a rising edge
// where ce=1. If ce=0, din_vld is ignored and the sender must hold the
// operands. dout_vld follows din_vld with exactly NUM_STAGE ce=1 edges of
// delay.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module decode_mul_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 40,
  parameter int din1_WIDTH = 21,
  parameter int dout_WIDTH = 32,
  parameter int SIGNED0    = 1,
  parameter int SIGNED1    = 1,
  parameter int SHIFT      = 16,
  parameter int ROUND      = 1,
  parameter int SAT        = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  din_vld,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  dout_vld,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  // The exact product of the two 1-bit-extended operands always fits in PW.
  localparam int PW = din0_WIDTH + din1_WIDTH + 2;
  // The post-product arithmetic width has one guard bit over PW so the
  // rounding add cannot overflow. It is also at least one bit wider than
  // dout, so the fit test always has high bits to examine.
  localparam int EW = (PW + 1 > dout_WIDTH + 1) ? PW + 1 : dout_WIDTH + 1;
  localparam bit OUT_SIGNED = (SIGNED0 != 0) || (SIGNED1 != 0);
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [EW-1:0] RND_ADD = (ROUND != 0 && SHIFT > 0) ? (EW'(1) << RND_SH) : '0;

  // Elaboration-time parameter legality.
  if (NUM_STAGE < 1 || NUM_STAGE > 6) begin : g_bad_num_stage
    $error("decode_mul_pipe: NUM_STAGE must be in 1..6");
  end
  if (SHIFT < 0 || SHIFT > din0_WIDTH + din1_WIDTH - 1) begin : g_bad_shift
    $error("decode_mul_pipe: SHIFT must be in 0..din0_WIDTH+din1_WIDTH-1");
  end
  if (ID < 0 || din0_WIDTH < 1 || din1_WIDTH < 1 || dout_WIDTH < 1) begin : g_bad_width
    $error("decode_mul_pipe: ID must be non-negative and widths at least 1");
  end

  //----------------------------------------------------------------------------
  // Operand extension and exact product
  //----------------------------------------------------------------------------
  logic signed [din0_WIDTH:0] a_ext;
  logic signed [din1_WIDTH:0] b_ext;
  logic signed [PW-1:0]       p_in;

  always_comb begin
    a_ext = {(SIGNED0 != 0) & din0[din0_WIDTH-1], din0};
    b_ext = {(SIGNED1 != 0) & din1[din1_WIDTH-1], din1};
    p_in  = PW'(a_ext) * PW'(b_ext);
  end

  //----------------------------------------------------------------------------
  // Product pipeline (NUM_STAGE-1 registers)
  //----------------------------------------------------------------------------
  logic signed [PW-1:0] p_last;
  logic                 vld_last;

  if (NUM_STAGE == 1) begin : g_no_pipe
    assign p_last   = p_in;
    assign vld_last = din_vld;
  end else begin : g_pipe
    localparam int D = NUM_STAGE - 1;
    logic signed [PW-1:0] p_d [D];
    logic signed [PW-1:0] p_q [D];
    logic [D-1:0]         vld_d;
    logic [D-1:0]         vld_q;

    always_comb begin
      p_d[0]   = p_in;
      vld_d[0] = din_vld;
      for (int i = 1; i < D; i++) begin
        p_d[i]   = p_q[i-1];
        vld_d[i] = vld_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < D; i++) p_q[i] <= '0;
        vld_q <= '0;
      end else if (ce) begin
        for (int i = 0; i < D; i++) p_q[i] <= p_d[i];
        vld_q <= vld_d;
      end
    end

    assign p_last   = p_q[D-1];
    assign vld_last = vld_q[D-1];
  end

  //----------------------------------------------------------------------------
  // Round, shift, saturate
  //----------------------------------------------------------------------------
  logic signed [EW-1:0]        p_ext;
  logic signed [EW-1:0]        r_sum;
  logic signed [EW-1:0]        r;
  logic [EW-dout_WIDTH:0]      hi_bits_s;  // bits that must be a sign copy when signed
  logic [EW-dout_WIDTH-1:0]    hi_bits_u;  // bits that must be zero when unsigned
  logic                        fits;
  logic [dout_WIDTH-1:0]       sat_val;
  logic [dout_WIDTH-1:0]       dout_d;
  logic                        ovf_d;
  logic                        dout_vld_d;

  always_comb begin
    p_ext     = EW'(p_last);
    r_sum     = p_ext + $signed(RND_ADD);
    r         = r_sum >>> SHIFT;
    hi_bits_s = r[EW-1:dout_WIDTH-1];
    hi_bits_u = r[EW-1:dout_WIDTH];
    if (OUT_SIGNED) begin
      fits    = (&hi_bits_s) || (~|hi_bits_s);
      sat_val = r[EW-1] ? {1'b1, {(dout_WIDTH-1){1'b0}}} : {1'b0, {(dout_WIDTH-1){1'b1}}};
    end else begin
      // A negative value cannot occur with two unsigned operands. It is still
      // clamped to 0 so the clamp direction never depends on that fact.
      fits    = ~|hi_bits_u;
      sat_val = r[EW-1] ? '0 : '1;
    end
    dout_d     = (!fits && SAT != 0) ? sat_val : r[dout_WIDTH-1:0];
    ovf_d      = !fits;
    dout_vld_d = vld_last;
  end

  //----------------------------------------------------------------------------
  // Output stage
  //----------------------------------------------------------------------------
  logic [dout_WIDTH-1:0] dout_q;
  logic                  ovf_q;
  logic                  dout_vld_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q     <= '0;
      ovf_q      <= 1'b0;
      dout_vld_q <= 1'b0;
    end else if (ce) begin
      dout_q     <= dout_d;
      ovf_q      <= ovf_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  assign dout     = dout_q;
  assign ovf      = ovf_q;
  assign dout_vld = dout_vld_q;

endmodule

// File: tb/tb_decode_mul_pipe.sv
//------------------------------------------------------------------------------
// tb_decode_mul_pipe
//   Four instances share one stimulus stream:
//     0: defaults
//     1: ROUND=0
//     2: SAT=0
//     3: unsigned, SHIFT=0, NUM_STAGE=1
//   Each accepted beat pushes the expected {due edge, ovf, dout} entry into
//   each instance's queue. A negedge monitor pops and compares an entry
//   whenever dout_vld is seen after a ce edge.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_decode_mul_pipe;

  localparam int NDUT = 4;
  localparam int W    = 53;  // {due[19:0], ovf, dout[31:0]}
  localparam int NS [NDUT] = '{3, 3, 3, 1};

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        din_vld;
  logic [39:0] din0;
  logic [20:0] din1;

  logic [NDUT-1:0] dv;
  logic [NDUT-1:0] dov;
  logic [31:0]     dd [NDUT];

  int n_tests = 0;
  int n_fail  = 0;
  int ce_edges = 0;
  int seen_edges = 0;

  logic [W-1:0] exp_q [NDUT][$];

  //---------------------------------------------------------------- clock/reset
  always #5 clk = ~clk;

  always @(posedge clk) if (ce && reset) ce_edges++;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time expired, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  //---------------------------------------------------------------- DUTs
  decode_mul_pipe u_def (
    .clk(clk), .reset(reset), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1),
    .dout_vld(dv[0]), .dout(dd[0]), .ovf(dov[0]));

  decode_mul_pipe #(.ROUND(0)) u_nornd (
    .clk(clk), .reset(reset), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1),
    .dout_vld(dv[1]), .dout(dd[1]), .ovf(dov[1]));

  decode_mul_pipe #(.SAT(0)) u_wrap (
    .clk(clk), .reset(reset), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1),
    .dout_vld(dv[2]), .dout(dd[2]), .ovf(dov[2]));

  decode_mul_pipe #(.SIGNED0(0), .SIGNED1(0), .SHIFT(0), .NUM_STAGE(1)) u_uns (
    .clk(clk), .reset(reset), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1),
    .dout_vld(dv[3]), .dout(dd[3]), .ovf(dov[3]));

  //---------------------------------------------------------------- model
  function automatic logic [31:0] model(input int idx, input logic [39:0] a,
                                        input logic [20:0] b, output logic o);
    int sh;
    bit rnd, sat, sg0, sg1;
    logic signed [127:0] pa, pb, p, r, lo, hi;
    sh = 16; rnd = 1; sat = 1; sg0 = 1; sg1 = 1;
    case (idx)
      1: rnd = 0;
      2: sat = 0;
      3: begin sg0 = 0; sg1 = 0; sh = 0; end
      default: ;
    endcase
    pa = sg0 ? {{88{a[39]}}, a} : {88'b0, a};
    pb = sg1 ? {{107{b[20]}}, b} : {107'b0, b};
    p  = pa * pb;
    if (rnd && sh > 0) p = p + (128'sd1 <<< (sh - 1));
    r = p >>> sh;
    if (sg0 || sg1) begin
      lo = -(128'sd1 <<< 31);
      hi = (128'sd1 <<< 31) - 128'sd1;
    end else begin
      lo = 128'sd0;
      hi = (128'sd1 <<< 32) - 128'sd1;
    end
    o = (r < lo) || (r > hi);
    if (sat && r > hi)      model = hi[31:0];
    else if (sat && r < lo) model = lo[31:0];
    else                    model = r[31:0];
  endfunction

  //---------------------------------------------------------------- driver
  task automatic drive(input logic c, input logic v, input logic [39:0] a, input logic [20:0] b);
    logic [31:0] e;
    logic        o;
    ce = c; din_vld = v; din0 = a; din1 = b;
    if (c && v) begin
      for (int i = 0; i < NDUT; i++) begin
        e = model(i, a, b, o);
        exp_q[i].push_back({20'(ce_edges + NS[i]), o, e});
      end
    end
    @(posedge clk); #1;
  endtask

  //---------------------------------------------------------------- scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (ce_edges != seen_edges) begin
      seen_edges = ce_edges;
      for (int i = 0; i < NDUT; i++) begin
        if (dv[i]) begin
          n_tests++;
          if (exp_q[i].size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_vld dut%0d: got dout_vld=1 dout=%h, required no result", i, dd[i]);
          end else begin
            e = exp_q[i].pop_front();
            if ({dd[i], dov[i]} !== {e[31:0], e[32]} || 20'(ce_edges) !== e[52:33]) begin
              n_fail++;
              $display("FAIL result dut%0d: got dout=%h ovf=%b at edge %0d, required dout=%h ovf=%b at edge %0d",
                       i, dd[i], dov[i], ce_edges, e[31:0], e[32], e[52:33]);
            end
          end
        end
      end
    end
  end

  //---------------------------------------------------------------- tests
  task automatic test_reset();
    reset = 1'b0; ce = 1'b0; din_vld = 1'b0; din0 = '0; din1 = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      n_tests++;
      if ({dv[i], dov[i], dd[i]} !== 34'b0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got vld=%b ovf=%b dout=%h, required 0", i, dv[i], dov[i], dd[i]);
      end
    end
    reset = 1'b1;
    ce = 1'b1;
  endtask

  task automatic test_basic();
    drive(1, 1, 40'd196608, 21'd2);
    drive(1, 1, 40'd98304, 21'd1);
    drive(1, 1, 40'(-98304), 21'd1);
    drive(1, 1, {1'b0, {39{1'b1}}}, {1'b0, {20{1'b1}}});
    drive(1, 1, {1'b1, 39'b0}, {1'b0, {20{1'b1}}});
    drive(1, 1, {40{1'b1}}, {21{1'b1}});
    drive(1, 0, 40'd12345, 21'd3);
    drive(1, 1, 40'(-1), 21'd1);
  endtask

  task automatic test_drain();
    int budget;
    din_vld = 1'b0; ce = 1'b1;
    budget = 0;
    while (budget < 10) begin
      @(posedge clk); #1;
      budget++;
    end
    for (int i = 0; i < NDUT; i++) begin
      n_tests++;
      if (exp_q[i].size() != 0) begin
        n_fail++;
        $display("FAIL drain_timeout dut%0d: got %0d results outstanding, required 0", i, exp_q[i].size());
        exp_q[i].delete();
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 12; k++)
      drive(1, 1, {8'($urandom()), $urandom()}, 21'($urandom()));
  endtask

  task automatic test_stall();
    logic [NDUT-1:0] s_dv, s_ov;
    logic [31:0]     s_dd [NDUT];
    drive(1, 1, 40'd65536, 21'd5);
    drive(1, 1, 40'(-131072), 21'd7);
    ce = 1'b0; din_vld = 1'b1; din0 = 40'd1000000; din1 = 21'd3;
    s_dv = dv; s_ov = dov;
    for (int i = 0; i < NDUT; i++) s_dd[i] = dd[i];
    repeat (2) begin
      @(posedge clk); #1;
      for (int i = 0; i < NDUT; i++) begin
        n_tests++;
        if ({dv[i], dov[i], dd[i]} !== {s_dv[i], s_ov[i], s_dd[i]}) begin
          n_fail++;
          $display("FAIL stall_hold dut%0d: got vld=%b ovf=%b dout=%h, required vld=%b ovf=%b dout=%h",
                   i, dv[i], dov[i], dd[i], s_dv[i], s_ov[i], s_dd[i]);
        end
      end
    end
    drive(1, 1, 40'd1000000, 21'd3);
  endtask

  task automatic test_reset_mid();
    drive(1, 1, 40'd300000, 21'd9);
    drive(1, 1, 40'(-300000), 21'd9);
    drive(1, 1, 40'd70000, 21'd70000);
    #1 reset = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      n_tests++;
      if ({dv[i], dov[i], dd[i]} !== 34'b0) begin
        n_fail++;
        $display("FAIL async_reset dut%0d: got vld=%b ovf=%b dout=%h, required 0", i, dv[i], dov[i], dd[i]);
      end
      exp_q[i].delete();
    end
    din_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      n_tests++;
      if (dv !== '0) begin
        n_fail++;
        $display("FAIL stale_vld: got dout_vld=%b, required 0000", dv);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++)
      drive(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
            {8'($urandom()), $urandom()}, 21'($urandom()));
  endtask

  //---------------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_basic();
    test_drain();
    test_back_to_back();
    test_drain();
    test_stall();
    test_drain();
    test_reset_mid();
    test_random();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
